// File: rtl/led_step_sequencer.sv
// led_step_sequencer
//   Avalon-MM slave that steps an LED pattern once every DIVIDE+1 rising
//   edges of the interval timer's timeout output. Modes: static,
//   rotate-left, rotate-right and bounce. A PWM stage scales brightness
//   on the registered LED outputs, and a wrap interrupt lets software
//   count full pattern cycles.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   tick        timer timeout; each rising edge counts as one timeout
//   address     register select (0 STATUS, 1 CONTROL, 2 PATTERN,
//               3 DIVIDE, 4 BRIGHT, 5 STEPCOUNT)
//   chipselect  slave select
//   write_n     active-low write
//   writedata   write data
//   readdata    registered read data, valid the cycle after address
//   irq         wrap interrupt (level) = wrap_flag & irq_en
//   led         registered, PWM-gated LED drive
module led_step_sequencer #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [15:0]         writedata,
  output logic [15:0]         readdata,
  output logic                irq,
  output logic [NUM_LEDS-1:0] led
);

  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_CONTROL   = 3'd1;
  localparam logic [2:0] ADDR_PATTERN   = 3'd2;
  localparam logic [2:0] ADDR_DIVIDE    = 3'd3;
  localparam logic [2:0] ADDR_BRIGHT    = 3'd4;
  localparam logic [2:0] ADDR_STEPCOUNT = 3'd5;

  localparam logic [PWM_BITS-1:0] PWM_ONE = 1;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTL   = 2'd1,
    MODE_ROTR   = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  logic [NUM_LEDS-1:0] pattern;
  mode_t               mode;
  logic                irq_en;
  logic                running;
  logic                wrap_flag;
  dir_t                dir;
  logic [7:0]          divide;
  logic [PWM_BITS-1:0] bright;
  logic [15:0]         step_count;
  logic [7:0]          div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick_d;

  logic wr, wr_status, wr_control, wr_pattern, wr_divide, wr_bright, wr_stepcount;
  logic tick_rise, step, step_taken, pwm_on;

  logic [NUM_LEDS-1:0] step_pattern;
  dir_t                step_dir;
  logic                step_wrap;
  logic [15:0]         rd_mux;

  // Upper writedata bits are unused for narrow parameterisations.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr           = chipselect & ~write_n;
  assign wr_status    = wr & (address == ADDR_STATUS);
  assign wr_control   = wr & (address == ADDR_CONTROL);
  assign wr_pattern   = wr & (address == ADDR_PATTERN);
  assign wr_divide    = wr & (address == ADDR_DIVIDE);
  assign wr_bright    = wr & (address == ADDR_BRIGHT);
  assign wr_stepcount = wr & (address == ADDR_STEPCOUNT);

  assign tick_rise = tick & ~tick_d;
  assign step      = running & tick_rise & (div_cnt == divide);
  // A PATTERN write in the same cycle swallows the step entirely.
  assign step_taken = step & ~wr_pattern;

  assign pwm_on = (&bright) | (pwm_cnt < bright);
  assign irq    = wrap_flag & irq_en;

  // Pattern, direction and wrap that a step would produce in the current mode.
  always_comb begin
    step_pattern = pattern;
    step_dir     = dir;
    step_wrap    = 1'b0;
    case (mode)
      MODE_ROTL: begin
        step_pattern = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
        step_wrap    = pattern[NUM_LEDS-1];
      end
      MODE_ROTR: begin
        step_pattern = {pattern[0], pattern[NUM_LEDS-1:1]};
        step_wrap    = pattern[0];
      end
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT && pattern[NUM_LEDS-1]) begin
          step_dir     = DIR_RIGHT;
          step_pattern = pattern >> 1;
          step_wrap    = 1'b1;
        end else if (dir == DIR_RIGHT && pattern[0]) begin
          step_dir     = DIR_LEFT;
          step_pattern = pattern << 1;
          step_wrap    = 1'b1;
        end else if (dir == DIR_LEFT) begin
          step_pattern = pattern << 1;
        end else begin
          step_pattern = pattern >> 1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:    rd_mux[1:0]          = {running, wrap_flag};
      ADDR_CONTROL:   rd_mux[2:0]          = {irq_en, mode};
      ADDR_PATTERN:   rd_mux[NUM_LEDS-1:0] = pattern;
      ADDR_DIVIDE:    rd_mux[7:0]          = divide;
      ADDR_BRIGHT:    rd_mux[PWM_BITS-1:0] = bright;
      ADDR_STEPCOUNT: rd_mux               = step_count;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata   <= '0;
      led        <= '0;
      pattern    <= {{(NUM_LEDS-1){1'b0}}, 1'b1};
      mode       <= MODE_STATIC;
      irq_en     <= 1'b0;
      running    <= 1'b0;
      wrap_flag  <= 1'b0;
      dir        <= DIR_LEFT;
      divide     <= '0;
      bright     <= '1;
      step_count <= '0;
      div_cnt    <= '0;
      pwm_cnt    <= '0;
      tick_d     <= 1'b0;
    end else begin
      tick_d   <= tick;
      pwm_cnt  <= pwm_cnt + PWM_ONE;
      led      <= pwm_on ? pattern : '0;
      readdata <= rd_mux;

      if (wr_control) begin
        mode   <= mode_t'(writedata[1:0]);
        irq_en <= writedata[2];
        // Start wins when both strobes are set.
        if (writedata[3])      running <= 1'b1;
        else if (writedata[4]) running <= 1'b0;
      end

      // div_cnt only moves while running, so a stop holds the partial count.
      if (wr_pattern || wr_divide)  div_cnt <= '0;
      else if (running && tick_rise) div_cnt <= (div_cnt == divide) ? 8'd0 : div_cnt + 8'd1;

      if (wr_divide) divide <= writedata[7:0];
      if (wr_bright) bright <= writedata[PWM_BITS-1:0];

      if (wr_pattern) begin
        pattern <= writedata[NUM_LEDS-1:0];
        dir     <= DIR_LEFT;
      end else if (step) begin
        pattern <= step_pattern;
        dir     <= step_dir;
      end

      if (wr_stepcount)    step_count <= '0;
      else if (step_taken) step_count <= step_count + 16'd1;

      if (wr_status)                    wrap_flag <= 1'b0;
      else if (step_taken && step_wrap) wrap_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_step_sequencer.sv
module tb_led_step_sequencer;

  localparam int N    = 8;
  localparam int PB   = 8;
  localparam int FULL = (1 << N) - 1;
  localparam int BMAX = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = 16'd0;
  logic [15:0]   readdata;
  logic          irq;
  logic [N-1:0]  led;

  led_step_sequencer #(.NUM_LEDS(N), .PWM_BITS(PB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .led        (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_pattern, m_mode, m_irq_en, m_running, m_wrap, m_dir;
  int m_divide, m_bright, m_sc, m_div, m_pwm, m_tickd, m_rd, m_led;
  int t_wr, t_a, t_wd, t_rise, t_step, t_div, t_top, t_bot;
  int t_np, t_nd, t_wrapc, t_rd, t_led;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pattern = 1; m_mode = 0; m_irq_en = 0; m_running = 0; m_wrap = 0;
      m_dir = 0; m_divide = 0; m_bright = BMAX; m_sc = 0; m_div = 0;
      m_pwm = 0; m_tickd = 0; m_rd = 0; m_led = 0;
    end else begin
      t_wr   = (chipselect && !write_n) ? 1 : 0;
      t_a    = int'(address);
      t_wd   = int'(writedata);
      t_rise = (tick && m_tickd == 0) ? 1 : 0;
      t_step = (m_running != 0 && t_rise != 0 && m_div == m_divide) ? 1 : 0;
      t_div  = m_div;
      if (m_running != 0 && t_rise != 0) t_div = (t_step != 0) ? 0 : m_div + 1;

      t_top = (m_pattern >> (N - 1)) & 1;
      t_bot = m_pattern & 1;
      t_np = m_pattern; t_nd = m_dir; t_wrapc = 0;
      case (m_mode)
        1: begin t_np = ((m_pattern * 2) & FULL) | t_top; t_wrapc = t_top; end
        2: begin t_np = (m_pattern / 2) | (t_bot << (N - 1)); t_wrapc = t_bot; end
        3: begin
          if (m_dir == 0 && t_top == 1) begin
            t_nd = 1; t_np = m_pattern / 2; t_wrapc = 1;
          end else if (m_dir == 1 && t_bot == 1) begin
            t_nd = 0; t_np = (m_pattern * 2) & FULL; t_wrapc = 1;
          end else begin
            t_np = (m_dir == 1) ? m_pattern / 2 : (m_pattern * 2) & FULL;
          end
        end
        default: ;
      endcase

      case (t_a)
        0: t_rd = m_running * 2 + m_wrap;
        1: t_rd = m_irq_en * 4 + m_mode;
        2: t_rd = m_pattern;
        3: t_rd = m_divide;
        4: t_rd = m_bright;
        5: t_rd = m_sc;
        default: t_rd = 0;
      endcase
      t_led = (m_bright == BMAX || m_pwm < m_bright) ? m_pattern : 0;

      if (t_step != 0 && !(t_wr != 0 && t_a == 2)) begin
        m_pattern = t_np; m_dir = t_nd; m_sc = (m_sc + 1) % 65536;
        if (t_wrapc != 0) m_wrap = 1;
      end
      if (t_wr != 0) begin
        case (t_a)
          0: m_wrap = 0;
          1: begin
            m_mode = t_wd & 3; m_irq_en = (t_wd >> 2) & 1;
            if (((t_wd >> 3) & 1) == 1)      m_running = 1;
            else if (((t_wd >> 4) & 1) == 1) m_running = 0;
          end
          2: begin m_pattern = t_wd & FULL; m_dir = 0; t_div = 0; end
          3: begin m_divide = t_wd & 255; t_div = 0; end
          4: m_bright = t_wd & BMAX;
          5: m_sc = 0;
          default: ;
        endcase
      end
      m_div = t_div;
      m_pwm = (m_pwm + 1) % (BMAX + 1);
      m_tickd = tick ? 1 : 0;
      m_rd = t_rd;
      m_led = t_led;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_readdata", int'(readdata), m_rd);
      check("model_led", int'(led), m_led);
      check("model_irq", int'(irq), (m_wrap != 0 && m_irq_en != 0) ? 1 : 0);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_wr(input int a, input int d);
    address = a[2:0]; writedata = d[15:0]; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input int a, output int v);
    address = a[2:0];
    @(posedge clk); #1;
    v = int'(readdata);
  endtask

  task automatic rd_check(input string name, input int a, input int exp);
    int v;
    bus_rd(a, v);
    check(name, v, exp);
  endtask

  task automatic pulse();
    tick = 1'b1; @(posedge clk); #1;
    tick = 1'b0; @(posedge clk); #1;
  endtask

  task automatic count_led(input int cycles, input int val, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (int'(led) == val) cnt++;
    end
    @(posedge clk); #1;
  endtask

  int cnt;
  int reset_vals [6] = '{0, 0, 1, 0, 255, 0};
  int bounce_pat [4] = '{8'h80, 8'h40, 8'h20, 8'h10};

  initial begin
    // Reset and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("led_in_reset", int'(led), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cmp_on = 1'b1;
    @(negedge clk);
    check("led_before_first_edge", int'(led), 0);
    @(posedge clk); #1;
    check("led_after_first_edge", int'(led), 1);
    for (int a = 0; a < 6; a++) rd_check("reset_read", a, reset_vals[a]);

    // Rotate-left, divide by 3
    bus_wr(1, 16'h000D);
    bus_wr(3, 2);
    repeat (9) pulse();
    rd_check("rotl_pattern", 2, 8'h08);
    rd_check("rotl_stepcount", 5, 3);
    check("rotl_irq_low", int'(irq), 0);

    // Wrap on rotate-left
    bus_wr(2, 8'h80);
    bus_wr(3, 0);
    bus_wr(0, 0);
    pulse();
    rd_check("wrap_pattern", 2, 8'h01);
    rd_check("wrap_status", 0, 3);
    check("wrap_irq_high", int'(irq), 1);
    bus_wr(0, 0);
    check("status_clear_irq", int'(irq), 0);
    // STATUS write coincident with a wrapping step
    bus_wr(2, 8'h80);
    tick = 1'b1; address = 3'd0; writedata = 16'd0; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
    @(posedge clk); #1;
    rd_check("coinc_pattern", 2, 8'h01);
    rd_check("coinc_status", 0, 2);

    // Bounce
    bus_wr(1, 16'h000F);
    bus_wr(2, 8'h40);
    bus_wr(0, 0);
    for (int i = 0; i < 4; i++) begin
      pulse();
      rd_check("bounce_pattern", 2, bounce_pat[i]);
      if (i == 0) rd_check("bounce_no_wrap_yet", 0, 2);
      if (i == 1) begin
        rd_check("bounce_wrap", 0, 3);
        bus_wr(0, 0);
      end
    end
    rd_check("bounce_single_wrap", 0, 2);

    // PWM brightness
    bus_wr(1, 16'h0008);
    bus_wr(2, 8'hFF);
    bus_wr(4, 8'h40);
    repeat (3) @(posedge clk); #1;
    count_led(512, 8'hFF, cnt);
    check("pwm_quarter_on", cnt, 128);
    bus_wr(4, 0);
    repeat (3) @(posedge clk); #1;
    count_led(300, 0, cnt);
    check("pwm_zero_off", cnt, 300);
    bus_wr(4, 8'hFF);
    repeat (3) @(posedge clk); #1;
    count_led(300, 8'hFF, cnt);
    check("pwm_full_on", cnt, 300);

    // Held tick gives one step
    bus_wr(5, 0);
    tick = 1'b1;
    repeat (20) @(posedge clk);
    #1 tick = 1'b0;
    @(posedge clk); #1;
    rd_check("held_tick_one_step", 5, 1);

    // Start and stop in one write
    bus_wr(1, 16'h0010);
    rd_check("stopped", 0, 0);
    bus_wr(1, 16'h0018);
    rd_check("start_wins", 0, 2);

    // PATTERN write against a step
    bus_wr(1, 16'h0009);
    bus_wr(5, 0);
    tick = 1'b1; address = 3'd2; writedata = 16'h005A; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
    @(posedge clk); #1;
    rd_check("pattern_write_wins", 2, 8'h5A);
    rd_check("pattern_write_no_count", 5, 0);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        writedata = (address == 3'd3) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
        writedata = 16'($urandom);
      end
      if (i == 1500) reset_n = 1'b0;
      if (i == 1502) reset_n = 1'b1;
      @(posedge clk); #1;
    end
    chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    cmp_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
